// File: rtl/m_std_pkg.sv
// Shared types for the std-cell wrapper family: strap sampler state encoding.
package m_std_pkg;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        SETTLE  = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    function automatic logic state_is_busy(input state_t st);
        return (st != LOCKED);
    endfunction

endpackage

// File: rtl/m_sync_ff.sv
// Vector synchronizer: STAGES-deep flop chain per bit, synchronous active-high clear.
// Latency STAGES cycles from d to q; no flow control.
module m_sync_ff #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

`ifdef TSMC_65
    logic [WIDTH-1:0] chain_d [STAGES];
    logic [WIDTH-1:0] chain_q [STAGES];

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        if (g == 0) begin : g_first
            assign chain_d[g] = rst ? '0 : d;
        end else begin : g_rest
            assign chain_d[g] = rst ? '0 : chain_q[g-1];
        end
        for (genvar b = 0; b < WIDTH; b++) begin : g_bit
            DFQD1 u_sync_ff (.D(chain_d[g][b]), .CP(clk), .Q(chain_q[g][b]));
        end
    end
    assign q = chain_q[STAGES-1];
`elsif TSMC16
    logic [WIDTH-1:0] chain_d [STAGES];
    logic [WIDTH-1:0] chain_q [STAGES];

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        if (g == 0) begin : g_first
            assign chain_d[g] = rst ? '0 : d;
        end else begin : g_rest
            assign chain_d[g] = rst ? '0 : chain_q[g-1];
        end
        for (genvar b = 0; b < WIDTH; b++) begin : g_bit
            DFQD1BWP16P90 u_sync_ff (.D(chain_d[g][b]), .CP(clk), .Q(chain_q[g][b]));
        end
    end
    assign q = chain_q[STAGES-1];
`else
    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[STAGES-1];
`endif

endmodule

// File: rtl/m_strap_sampler.sv
// Strap sampler: synchronize, qualify for STABLE_CYCLES equal samples, latch and monitor.
// First lock SYNC_STAGES+STABLE_CYCLES+1 cycles after reset release; no flow control.
module m_strap_sampler
    import m_std_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 16,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] strap_in,
    input  logic             resample,
    output logic [WIDTH-1:0] strap_out,
    output logic             strap_valid,
    output logic             busy,
    output logic             change_err
);

    localparam int FILL_W = $clog2(SYNC_STAGES + 1);
    localparam logic [FILL_W-1:0] FILL_LAST   = FILL_W'(SYNC_STAGES - 1);
    localparam logic [CNT_W-1:0]  STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  STABLE_SAT  = CNT_W'(STABLE_CYCLES);

    logic [WIDTH-1:0]  s;

    state_t            state, state_nxt;
    logic [FILL_W-1:0] fill_cnt, fill_cnt_nxt;
    logic              load, load_nxt;
    logic [WIDTH-1:0]  cand, cand_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [CNT_W-1:0]  mcnt, mcnt_nxt;
    logic [WIDTH-1:0]  out_q, out_nxt;
    logic              valid_q, valid_nxt;
    logic              err_q, err_nxt;

    m_sync_ff #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (strap_in),
        .q   (s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        fill_cnt_nxt = fill_cnt;
        load_nxt     = load;
        cand_nxt     = cand;
        cnt_nxt      = cnt;
        mcnt_nxt     = mcnt;
        out_nxt      = out_q;
        valid_nxt    = valid_q;
        err_nxt      = err_q;

        unique case (state)
            FILL: begin
                // Wait until the synchronizer chain holds real samples.
                if (fill_cnt == FILL_LAST) begin
                    fill_cnt_nxt = '0;
                    load_nxt     = 1'b1;
                    state_nxt    = SETTLE;
                end else begin
                    fill_cnt_nxt = fill_cnt + FILL_W'(1);
                end
            end

            SETTLE: begin
                if (load) begin
                    load_nxt = 1'b0;
                    cand_nxt = s;
                    cnt_nxt  = '0;
                end else if (s != cand) begin
                    cand_nxt = s;
                    cnt_nxt  = '0;
                end else if (cnt == STABLE_LAST) begin
                    out_nxt   = cand;
                    valid_nxt = 1'b1;
                    cnt_nxt   = '0;
                    mcnt_nxt  = '0;
                    state_nxt = LOCKED;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            LOCKED: begin
                // A resample request overrides a change error raised on the same edge.
                if (resample) begin
                    valid_nxt = 1'b0;
                    err_nxt   = 1'b0;
                    mcnt_nxt  = '0;
                    load_nxt  = 1'b1;
                    state_nxt = SETTLE;
                end else if (s != out_q) begin
                    if (mcnt == STABLE_LAST) begin
                        mcnt_nxt = STABLE_SAT;
                        err_nxt  = 1'b1;
                    end else if (mcnt != STABLE_SAT) begin
                        mcnt_nxt = mcnt + CNT_W'(1);
                    end
                end else begin
                    mcnt_nxt = '0;
                end
            end

            default: begin
                state_nxt = FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_cnt <= '0;
            load     <= 1'b0;
            cand     <= '0;
            cnt      <= '0;
            mcnt     <= '0;
            out_q    <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            fill_cnt <= fill_cnt_nxt;
            load     <= load_nxt;
            cand     <= cand_nxt;
            cnt      <= cnt_nxt;
            mcnt     <= mcnt_nxt;
            out_q    <= out_nxt;
            valid_q  <= valid_nxt;
            err_q    <= err_nxt;
        end
    end

    assign strap_out   = out_q;
    assign strap_valid = valid_q;
    assign change_err  = err_q;
    assign busy        = state_is_busy(state);

endmodule
